// File: rtl/beep_pkg.sv
// Shared constants for the buzzer pattern sequencer.
package beep_pkg;

  // Request modes; code 3 is reserved and decoded as a click.
  localparam logic [1:0] MODE_CLICK = 2'd0;
  localparam logic [1:0] MODE_CHIME = 2'd1;
  localparam logic [1:0] MODE_ALARM = 2'd2;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Pattern segment lengths in timing units, and alarm group size.
  localparam int unsigned CLICK_ON    = 1;
  localparam int unsigned CHIME_ON    = 2;
  localparam int unsigned CHIME_OFF   = 2;
  localparam int unsigned ALARM_ON    = 1;
  localparam int unsigned ALARM_OFF   = 1;
  localparam int unsigned ALARM_BEEPS = 4;
  localparam int unsigned ALARM_GAP   = 4;

  // Width of the per-segment unit counter; must hold the longest segment.
  localparam int unsigned SEG_W = 3;

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave tone divider: toggles every HALF cycles while running.
module beep_tone_gen #(
  parameter int unsigned HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic tone
);

  localparam int unsigned PH_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic            tone_q, tone_d;

  // Restart starts a fresh high half-period; otherwise advance only while running.
  always_comb begin
    phase_d = phase_q;
    tone_d  = tone_q;
    if (restart) begin
      phase_d = '0;
      tone_d  = 1'b1;
    end else if (run) begin
      if (phase_q == PH_W'(HALF - 1)) begin
        phase_d = '0;
        tone_d  = ~tone_q;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  // Phase and tone registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      tone_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tone_q  <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/beep_sequencer.sv
// Buzzer pattern sequencer: click, N-beep chime and repeating alarm.
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TONE_HZ = 2_000,
  parameter int unsigned UNIT_MS = 100,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beep_enabled,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [CNT_W-1:0] req_count,
  input  logic             stop,
  output logic             busy,
  output logic             beep_port
);

  localparam int unsigned HALF   = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned UNIT   = (CLK_HZ / 1000) * UNIT_MS;
  localparam int unsigned UNIT_W = (UNIT > 1) ? $clog2(UNIT) : 1;
  localparam int unsigned BEAT_W = (CNT_W > 2) ? CNT_W : 2;

  // Reject configurations where a unit cannot hold a full tone period.
  generate
    if (HALF < 1 || UNIT < 2 * HALF) begin : g_bad_cfg
      $error("beep_sequencer: illegal CLK_HZ/TONE_HZ/UNIT_MS combination");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              beep_port_q, beep_port_d;

  logic [1:0]        req_mode_n;
  logic [SEG_W-1:0]  seg_units;
  logic              unit_end, seg_end;
  logic              tone, tone_restart, tone_run;

  // Reserved mode code decodes as a click.
  assign req_mode_n = (req_mode == MODE_CHIME || req_mode == MODE_ALARM) ? req_mode : MODE_CLICK;

  // Length in units of the segment currently being timed.
  always_comb begin
    seg_units = SEG_W'(1);
    case (state_q)
      ST_ON:   seg_units = (mode_q == MODE_CHIME) ? SEG_W'(CHIME_ON)
                         : (mode_q == MODE_ALARM) ? SEG_W'(ALARM_ON) : SEG_W'(CLICK_ON);
      ST_OFF:  seg_units = (mode_q == MODE_CHIME) ? SEG_W'(CHIME_OFF) : SEG_W'(ALARM_OFF);
      ST_GAP:  seg_units = SEG_W'(ALARM_GAP);
      default: seg_units = SEG_W'(1);
    endcase
  end

  assign unit_end = (unit_q == UNIT_W'(UNIT - 1));
  assign seg_end  = unit_end && (seg_q == seg_units - SEG_W'(1));

  // Next-state, timers and beep counter; stop overrides everything.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unit_d  = unit_q;
    seg_d   = seg_q;
    beat_d  = beat_q;
    if (stop) begin
      state_d = ST_IDLE;
      mode_d  = MODE_CLICK;
      unit_d  = '0;
      seg_d   = '0;
      beat_d  = '0;
    end else if (state_q == ST_IDLE) begin
      if (req_valid) begin
        state_d = ST_ON;
        mode_d  = req_mode_n;
        unit_d  = '0;
        seg_d   = '0;
        if (req_mode_n == MODE_CHIME)
          beat_d = (req_count == '0) ? BEAT_W'(1) : BEAT_W'(req_count);
        else
          beat_d = '0;
      end
    end else if (seg_end) begin
      unit_d = '0;
      seg_d  = '0;
      case (state_q)
        ST_ON: begin
          if (mode_q == MODE_ALARM) begin
            state_d = ST_OFF;
          end else if (mode_q == MODE_CHIME && beat_q != BEAT_W'(1)) begin
            state_d = ST_OFF;
            beat_d  = beat_q - BEAT_W'(1);
          end else begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end
        end
        ST_OFF: begin
          if (mode_q == MODE_ALARM && beat_q == BEAT_W'(ALARM_BEEPS - 1)) begin
            state_d = ST_GAP;
            beat_d  = '0;
          end else begin
            state_d = ST_ON;
            if (mode_q == MODE_ALARM) beat_d = beat_q + BEAT_W'(1);
          end
        end
        default: state_d = ST_ON;
      endcase
    end else if (unit_end) begin
      unit_d = '0;
      seg_d  = seg_q + SEG_W'(1);
    end else begin
      unit_d = unit_q + UNIT_W'(1);
    end
  end

  // Tone restarts on each entry into ON and only advances while ON.
  assign tone_restart = (state_d == ST_ON) && (state_q != ST_ON);
  assign tone_run     = (state_q == ST_ON);

  beep_tone_gen #(
    .HALF (HALF)
  ) u_tone (
    .clk     (clk),
    .rst     (rst | stop),
    .restart (tone_restart),
    .run     (tone_run),
    .tone    (tone)
  );

  // Registered handshake/status and gated buzzer drive.
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    beep_port_d = (state_q == ST_ON) & tone & beep_enabled & ~stop;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CLICK;
      unit_q      <= '0;
      seg_q       <= '0;
      beat_q      <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      beep_port_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      unit_q      <= unit_d;
      seg_q       <= seg_d;
      beat_q      <= beat_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      beep_port_q <= beep_port_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign beep_port = beep_port_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer against a timeline reference model.
module tb_beep_sequencer;

  // HALF = 1000/(2*100) = 5 cycles, UNIT = (1000/1000)*10 = 10 cycles.
  localparam int H = 5;
  localparam int U = 10;

  logic       clk = 1'b0;
  logic       rst, beep_enabled, req_valid, stop;
  logic [1:0] req_mode;
  logic [3:0] req_count;
  logic       req_ready, busy, beep_port;

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  // Reference model: pattern offset since the accepting edge.
  bit m_active = 1'b0;
  int m_mode   = 0;
  int m_n      = 1;
  int m_t      = 0;
  bit e_beep   = 1'b0;
  bit e_busy   = 1'b0;
  bit e_ready  = 1'b1;

  always #5 clk = ~clk;

  beep_sequencer #(
    .CLK_HZ  (1000),
    .TONE_HZ (100),
    .UNIT_MS (10),
    .CNT_W   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .beep_enabled (beep_enabled),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_count    (req_count),
    .stop         (stop),
    .busy         (busy),
    .beep_port    (beep_port)
  );

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Where pattern offset t lands: tone gated on, phase within the ON segment, finished.
  function automatic void seg_info(input int mode, input int n, input int t,
                                   output bit on, output int s, output bit done);
    int p;
    on = 1'b0; s = 0; done = 1'b0;
    if (mode == 1) begin
      done = (t >= n * 4 * U - 2 * U);
      p    = t % (4 * U);
      on   = (p < 2 * U);
      s    = p;
    end else if (mode == 2) begin
      p = t % (12 * U);
      if (p < 8 * U) begin
        on = ((p % (2 * U)) < U);
        s  = p % (2 * U);
      end
    end else begin
      done = (t >= U);
      on   = (t < U);
      s    = t;
    end
  endfunction

  // Advance the model across one clock edge using the inputs held over the cycle.
  task automatic model_edge();
    bit on, done;
    int s;
    on = 1'b0; done = 1'b0; s = 0;
    if (m_active) seg_info(m_mode, m_n, m_t, on, s, done);
    e_beep = !rst && !stop && m_active && on && (((s / H) % 2) == 0) && beep_enabled;
    if (rst || stop) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_t++;
      seg_info(m_mode, m_n, m_t, on, s, done);
      if (done) m_active = 1'b0;
    end else if (req_valid) begin
      m_active = 1'b1;
      m_t      = 0;
      m_mode   = (req_mode == 2'd1 || req_mode == 2'd2) ? int'(req_mode) : 0;
      m_n      = (req_count == 4'd0) ? 1 : int'(req_count);
    end
    e_busy  = m_active;
    e_ready = !m_active;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq({phase, ".beep_port"}, beep_port, e_beep);
    check_eq({phase, ".busy"}, busy, e_busy);
    check_eq({phase, ".req_ready"}, req_ready, e_ready);
  endtask

  task automatic request(input logic [1:0] mode, input logic [3:0] cnt);
    req_mode  = mode;
    req_count = cnt;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; beep_enabled = 1'b1; req_valid = 1'b1; stop = 1'b0;
    req_mode = 2'd0; req_count = 4'd0;

    phase = "reset";
    repeat (3) tick();
    rst = 1'b0; req_valid = 1'b0;
    tick();

    phase = "click";
    request(2'd0, 4'd0);
    repeat (15) tick();

    phase = "chime3";
    request(2'd1, 4'd3);
    repeat (110) tick();

    phase = "chime0";
    request(2'd1, 4'd0);
    repeat (30) tick();

    phase = "reserved_mode";
    request(2'd3, 4'd7);
    repeat (15) tick();

    phase = "alarm";
    request(2'd2, 4'd5);
    repeat (249) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (5) tick();

    phase = "stop_vs_req";
    stop = 1'b1; req_valid = 1'b1; req_mode = 2'd0;
    tick();
    stop = 1'b0; req_valid = 1'b0;
    repeat (12) tick();

    phase = "mute";
    beep_enabled = 1'b0;
    request(2'd1, 4'd2);
    repeat (44) tick();
    beep_enabled = 1'b1;
    repeat (25) tick();

    phase = "collision";
    request(2'd1, 4'd1);
    req_mode = 2'd0; req_valid = 1'b1;
    repeat (22) tick();
    req_valid = 1'b0;
    repeat (12) tick();

    phase = "random";
    repeat (3000) begin
      rst       = ($urandom_range(0, 499) == 0);
      stop      = ($urandom_range(0, 199) == 0);
      req_valid = ($urandom_range(0, 15) == 0);
      req_mode  = 2'($urandom_range(0, 3));
      req_count = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) beep_enabled = ~beep_enabled;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
